// File: rtl/mem_split32.sv
// Splits 32-bit CPU word requests into two 16-bit SRAM sequencer transactions and reassembles reads.
// Optional macro MEM_SPLIT_HALF_EN adds req_half for single half-word accesses.
module mem_split32 #(
    parameter int ADDR_W   = 32,
    parameter int HI_FIRST = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
`ifdef MEM_SPLIT_HALF_EN
    input  logic              req_half,
`endif
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              valid,
    output logic              rw,
    output logic [ADDR_W-1:0] addri,
    output logic [15:0]       dtw,
    input  logic [15:0]       dtr,
    input  logic              done
);

    localparam logic FIRST_HI = (HI_FIRST != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT0 = 2'd1,
        WAIT1 = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              ready_reg, ready_next;
    logic              resp_valid_reg, resp_valid_next;
    logic [31:0]       resp_rdata_reg, resp_rdata_next;
    logic              valid_reg, valid_next;
    logic              rw_reg, rw_next;
    logic [ADDR_W-1:0] addri_reg, addri_next;
    logic [15:0]       dtw_reg, dtw_next;
    logic [ADDR_W-3:0] word_reg, word_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [15:0]       first_reg, first_next;
    logic              half_reg, half_next;

    logic half_in;
    logic first_hi_in;
    logic unused_addr_bits;

`ifdef MEM_SPLIT_HALF_EN
    assign half_in = req_half;
`else
    assign half_in = 1'b0;
`endif

    // A half-word request picks its only half from addr[1]; word requests follow HI_FIRST.
    assign first_hi_in      = half_in ? req_addr[1] : FIRST_HI;
    assign unused_addr_bits = ^req_addr[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            ready_reg      <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            valid_reg      <= 1'b0;
            rw_reg         <= 1'b0;
            addri_reg      <= '0;
            dtw_reg        <= '0;
            word_reg       <= '0;
            wdata_reg      <= '0;
            first_reg      <= '0;
            half_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ready_reg      <= ready_next;
            resp_valid_reg <= resp_valid_next;
            resp_rdata_reg <= resp_rdata_next;
            valid_reg      <= valid_next;
            rw_reg         <= rw_next;
            addri_reg      <= addri_next;
            dtw_reg        <= dtw_next;
            word_reg       <= word_next;
            wdata_reg      <= wdata_next;
            first_reg      <= first_next;
            half_reg       <= half_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ready_next      = ready_reg;
        resp_valid_next = 1'b0;
        resp_rdata_next = resp_rdata_reg;
        valid_next      = 1'b0;
        rw_next         = rw_reg;
        addri_next      = addri_reg;
        dtw_next        = dtw_reg;
        word_next       = word_reg;
        wdata_next      = wdata_reg;
        first_next      = first_reg;
        half_next       = half_reg;

        case (state_reg)
            IDLE: begin
                ready_next = 1'b1;
                if (req_valid) begin
                    rw_next    = req_rw;
                    word_next  = req_addr[ADDR_W-1:2];
                    wdata_next = req_wdata;
                    half_next  = half_in;
                    ready_next = 1'b0;
                    valid_next = 1'b1;
                    addri_next = {req_addr[ADDR_W-1:2], first_hi_in, 1'b0};
                    dtw_next   = (!half_in && FIRST_HI) ? req_wdata[31:16] : req_wdata[15:0];
                    state_next = WAIT0;
                end
            end

            // done coinciding with our own launch pulse belongs to no transaction of ours.
            WAIT0: begin
                if (done && !valid_reg) begin
                    first_next = dtr;
                    if (half_reg) begin
                        resp_valid_next = 1'b1;
                        resp_rdata_next = rw_reg ? 32'h0 : {16'h0, dtr};
                        ready_next      = 1'b1;
                        state_next      = IDLE;
                    end else begin
                        valid_next = 1'b1;
                        addri_next = {word_reg, ~FIRST_HI, 1'b0};
                        dtw_next   = FIRST_HI ? wdata_reg[15:0] : wdata_reg[31:16];
                        state_next = WAIT1;
                    end
                end
            end

            WAIT1: begin
                if (done && !valid_reg) begin
                    resp_valid_next = 1'b1;
                    if (rw_reg) begin
                        resp_rdata_next = 32'h0;
                    end else if (FIRST_HI) begin
                        resp_rdata_next = {first_reg, dtr};
                    end else begin
                        resp_rdata_next = {dtr, first_reg};
                    end
                    ready_next = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                ready_next = 1'b1;
            end
        endcase
    end

    assign req_ready  = ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign valid      = valid_reg;
    assign rw         = rw_reg;
    assign addri      = addri_reg;
    assign dtw        = dtw_reg;

endmodule

// File: tb/tb_mem_split32.sv
// Self-checking bench for mem_split32: behavioural SRAM sequencer plus directed and random word requests.
module tb_mem_split32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
`ifdef MEM_SPLIT_HALF_EN
    logic        req_half = 1'b0;
`endif
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        valid;
    logic        rw;
    logic [31:0] addri;
    logic [15:0] dtw;
    logic [15:0] dtr = '0;
    logic        done = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        rw;
        logic [31:0] a;
        logic [15:0] d;
    } launch_t;

    logic [15:0] mem [logic [31:0]];
    launch_t     launches[$];
    int          seq_lat = 5;

    mem_split32 #(.ADDR_W(32), .HI_FIRST(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
`ifdef MEM_SPLIT_HALF_EN
        .req_half   (req_half),
`endif
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .valid      (valid),
        .rw         (rw),
        .addri      (addri),
        .dtw        (dtw),
        .dtr        (dtr),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dflt(input logic [31:0] a);
        return a[16:1] ^ 16'hC3A5 ^ {a[7:0], a[15:8]};
    endfunction

    function automatic logic [15:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return dflt(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sequencer model: samples a launch, answers with done after seq_lat cycles, checks the hold rule.
    initial begin : seq_model
        launch_t l;
        bit      abort;
        forever begin
            @(negedge clk);
            if (reset && valid) begin
                l.rw = rw;
                l.a  = addri;
                l.d  = dtw;
                launches.push_back(l);
                abort = 1'b0;
                for (int i = 0; i < seq_lat - 1; i++) begin
                    @(posedge clk);
                    if (!reset) abort = 1'b1;
                end
                if (!abort) begin
                    #1;
                    if (reset) begin
                        chk("hold_addri", addri, l.a);
                        chk("hold_dtw", dtw, l.d);
                        chk("hold_rw", rw, l.rw);
                        chk("valid_low_before_done", valid, 1'b0);
                        dtr = rd(l.a);
                        if (l.rw) mem[l.a] = l.d;
                        done = 1'b1;
                        @(posedge clk);
                        #1 done = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_resp(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!resp_valid && cyc < 100);
    endtask

    task automatic run_word(input logic rwv, input logic [31:0] a, input logic [31:0] wd,
                            input int lat, input string tag);
        logic [31:0] base;
        logic [31:0] exp;
        int          cyc;
        launch_t     e0, e1;
        seq_lat = lat;
        base = {a[31:2], 2'b00};
        exp  = rwv ? 32'h0 : {rd(base + 32'd2), rd(base)};
        launches.delete();
        chk({tag, "_ready_idle"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_rw    = rwv;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk({tag, "_ready_busy"}, req_ready, 1'b0);
        chk({tag, "_valid0"}, valid, 1'b1);
        chk({tag, "_addri0"}, addri, base);
        wait_resp(cyc);
        chk({tag, "_latency"}, cyc, 2 * lat);
        chk({tag, "_rdata"}, resp_rdata, exp);
        @(posedge clk);
        #1;
        chk({tag, "_resp_pulse"}, resp_valid, 1'b0);
        chk({tag, "_rdata_hold"}, resp_rdata, exp);
        chk({tag, "_nlaunch"}, launches.size(), 2);
        if (launches.size() == 2) begin
            e0 = '{rw: rwv, a: base, d: wd[15:0]};
            e1 = '{rw: rwv, a: base + 32'd2, d: wd[31:16]};
            chk({tag, "_launch_lo"}, launches[0], e0);
            chk({tag, "_launch_hi"}, launches[1], e1);
        end
        $display("req %s rw=%0d addr=%h wdata=%h lat=%0d -> rdata=%h cycles=%0d",
                 tag, rwv, a, wd, lat, resp_rdata, cyc);
    endtask

    initial begin : main
        int          cyc;
        int          seen;
        logic [31:0] w;
        launch_t     e;

        // Reset state
        #1 reset = 1'b0;
        #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_rw", rw, 1'b0);
        chk("rst_addri", addri, 32'h0);
        chk("rst_dtw", dtw, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        // Read with known data
        mem[32'h1004] = 16'hBEEF;
        mem[32'h1006] = 16'hDEAD;
        run_word(1'b0, 32'h0000_1004, $urandom, 5, "rd1004");
        chk("rd1004_const", resp_rdata, 32'hDEAD_BEEF);

        // Write
        run_word(1'b1, 32'h0000_2000, 32'h1234_5678, 5, "wr2000");
        chk("wr2000_mem_lo", rd(32'h2000), 16'h5678);
        chk("wr2000_mem_hi", rd(32'h2002), 16'h1234);

        // Misaligned address
        run_word(1'b0, 32'h0000_3003, $urandom, 5, "rd3003");

        // Spurious done while idle
        done = 1'b1;
        @(posedge clk);
        #1 done = 1'b0;
        chk("spur_ready", req_ready, 1'b1);
        chk("spur_valid", valid, 1'b0);
        chk("spur_resp", resp_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("spur_valid2", valid, 1'b0);
        chk("spur_ready2", req_ready, 1'b1);
        $display("req spurious_done ready=%0d valid=%0d", req_ready, valid);

        // Back-to-back: write then read of the same word, second request held during the first
        launches.delete();
        seq_lat = 5;
        w = $urandom;
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_addr  = 32'h5000;
        req_wdata = w;
        @(posedge clk);
        #1;
        req_rw    = 1'b0;
        req_wdata = 32'hFFFF_FFFF;
        wait_resp(cyc);
        chk("b2b_lat1", cyc, 10);
        chk("b2b_rdata1", resp_rdata, 32'h0);
        chk("b2b_ready_in_resp", req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("b2b_valid2", valid, 1'b1);
        chk("b2b_addri2", addri, 32'h5000);
        chk("b2b_ready2", req_ready, 1'b0);
        chk("b2b_resp_cleared", resp_valid, 1'b0);
        wait_resp(cyc);
        chk("b2b_lat2", cyc, 10);
        chk("b2b_rdata2", resp_rdata, w);
        @(posedge clk);
        #1;
        chk("b2b_nlaunch", launches.size(), 4);
        if (launches.size() == 4) begin
            e = '{rw: 1'b0, a: 32'h5000, d: 16'hFFFF};
            chk("b2b_launch2", launches[2], e);
            e = '{rw: 1'b0, a: 32'h5002, d: 16'hFFFF};
            chk("b2b_launch3", launches[3], e);
        end
        $display("req b2b write/read addr=5000 data=%h -> rdata=%h", w, resp_rdata);

        // Reset in WAIT1
        launches.delete();
        seq_lat = 5;
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_addr  = 32'h6000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("mrst_ready", req_ready, 1'b1);
        chk("mrst_valid", valid, 1'b0);
        chk("mrst_resp", resp_valid, 1'b0);
        chk("mrst_rdata", resp_rdata, 32'h0);
        chk("mrst_rw", rw, 1'b0);
        chk("mrst_addri", addri, 32'h0);
        chk("mrst_dtw", dtw, 16'h0);
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid || valid) seen++;
        end
        chk("mrst_no_activity", seen, 0);
        chk("mrst_ready_after", req_ready, 1'b1);
        chk("mrst_nlaunch", launches.size(), 2);
        $display("req reset_in_wait1 launches=%0d activity_after=%0d", launches.size(), seen);

`ifdef MEM_SPLIT_HALF_EN
        // Half-word read
        mem[32'h4002] = 16'hCAFE;
        launches.delete();
        seq_lat = 5;
        w = $urandom;
        req_valid = 1'b1;
        req_half  = 1'b1;
        req_rw    = 1'b0;
        req_addr  = 32'h4002;
        req_wdata = w;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_half = 1'b0;
        chk("half_addri", addri, 32'h4002);
        wait_resp(cyc);
        chk("half_lat", cyc, 5);
        chk("half_rdata", resp_rdata, 32'h0000_CAFE);
        @(posedge clk);
        #1;
        chk("half_nlaunch", launches.size(), 1);
        if (launches.size() == 1) begin
            e = '{rw: 1'b0, a: 32'h4002, d: w[15:0]};
            chk("half_launch", launches[0], e);
        end
        $display("req half_read addr=4002 -> rdata=%h cycles=%0d", resp_rdata, cyc);
`endif

        // Random word traffic over a small window so reads hit earlier writes
        for (int n = 0; n < 20; n++) begin
            run_word(1'($urandom_range(0, 1)), 32'h7000 + 32'($urandom_range(0, 63)),
                     $urandom, int'($urandom_range(2, 8)), $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_split32.md
Name: mem_split32

Overview:
- Upstream feeder for the external 16-bit SRAM sequencer.
- Accepts 32-bit word read/write requests from the CPU load/store path.
- Issues two sequential 16-bit transactions: low half first, then high half.
- Assembles the read result and returns a single response pulse.

Parameters:
ADDR_W, 32, request/SRAM address width
HI_FIRST, 0, 1 = issue the high half before the low half (data mapping is unchanged)

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  CPU request present
req_ready  out  1  block idle and able to accept
req_rw  in  1  1 = write
req_addr  in  ADDR_W  byte address; bits [1:0] ignored
req_wdata  in  32  write data
resp_valid  out  1  one-cycle pulse: request complete
resp_rdata  out  32  read data, valid while resp_valid (0 for writes)
valid  out  1  one-cycle launch pulse to SRAM sequencer
rw  out  1  to sequencer; 1 = write
addri  out  ADDR_W  half-word address to sequencer
dtw  out  16  half-word write data
dtr  in  16  half-word read data from sequencer
done  in  1  one-cycle completion pulse from sequencer

Behaviour:
- Reset values (reset low, async): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, valid=0, rw=0, addri=0, dtw=0, internal latches 0.
- States: IDLE, WAIT0, WAIT1. All outputs are registered.
- IDLE:
  - req_ready=1.
  - On req_valid at a posedge: latch rw/addr/wdata; req_ready<=0; valid<=1; state<=WAIT0.
  - addri and dtw take the first half, per the mapping below.
- Half mapping:
  - low half: addri={addr[ADDR_W-1:2],2'b00}, dtw=wdata[15:0].
  - high half: addri={addr[ADDR_W-1:2],2'b10}, dtw=wdata[31:16].
- Launch and hold rules:
  - valid is high for exactly one cycle per half; it is cleared on the next posedge.
  - addri, rw and dtw are held stable from the launch cycle until done is sampled.
  - The sequencer reads addri over two cycles and dtw later, so holding these signals is mandatory.
- WAIT0, done sampled high:
  - Capture dtr into the first-half slot.
  - Same edge: drive the second-half addri/dtw, set valid<=1, state<=WAIT1.
  - valid is therefore low during the sequencer's done cycle. This prevents re-launching the completed half.
- WAIT1, done sampled high:
  - Capture dtr into the second-half slot.
  - Same edge: resp_valid<=1; resp_rdata<={hi,lo} for reads, 0 for writes; state<=IDLE; req_ready<=1.
- resp_valid and resp_rdata:
  - resp_valid clears the following cycle.
  - resp_rdata holds its value until the next response.
- A new request can be accepted in the same cycle that resp_valid is high, i.e. back-to-back operation.
- done in IDLE, or done in the same cycle valid is high, is ignored (no state change).
- Latency, with the sequencer taking 5 cycles from launch to visible done:
  - accept edge A; first valid is visible after A.
  - second launch at A+5; resp_valid is visible after edge A+10.
- Reset mid-operation:
  - Immediate return to reset values; no response is issued.
  - The sequencer's own reset is asserted together with this one at system level.
- req_addr[1:0] != 0: the address is silently word-aligned; no error is raised.

Optional Feature:
- Macro: MEM_SPLIT_HALF_EN.
- Defined:
  - Adds input req_half (1 bit), latched at accept.
  - When req_half=1, only one transaction is issued: low half if addr[1]=0, high half if addr[1]=1.
  - For that single transaction, dtw=wdata[15:0] regardless of addr[1].
  - The FSM goes WAIT0 -> IDLE with resp_valid.
  - For reads, resp_rdata={16'b0,dtr}. Latency is 5 cycles.
- Undefined: port absent; every request is a two-half word access.

Test Plan:
- Read, addr 0x0000_1004, sequencer returns 0xBEEF then 0xDEAD:
  - two valid pulses, with addri 0x1004 then 0x1006;
  - resp_valid is one cycle, with resp_rdata 0xDEADBEEF, 10 cycles after accept.
- Write, addr 0x0000_2000, wdata 0x1234_5678:
  - dtw=0x5678 with rw=1, held until first done;
  - then dtw=0x1234 at addri 0x2002;
  - resp_rdata=0.
- Back-to-back: a second request held on req_valid is accepted in the resp_valid cycle; the next valid pulse follows one cycle later, with no lost or duplicated launch.
- Reset: reset driven low in WAIT1 -> all outputs 0 and req_ready=1 asynchronously; no resp_valid after release.
- Spurious done in IDLE, and misaligned addr 0x3003 -> no state change for the former; addri 0x3000/0x3002 for the latter.
- MEM_SPLIT_HALF_EN: half read at 0x0000_4002 returning 0xCAFE -> one valid at addri 0x4002; resp_rdata 0x0000_CAFE.
